// File: rtl/column_feeder_if.sv
// column_feeder_if: frame-in / column-out bus between capture stage, feeder and QR array
interface column_feeder_if;
    logic         data_valid;
    logic [767:0] h;
    logic [191:0] y;
    logic         col_valid;
    logic         col_ready;
    logic [191:0] col;
    logic [2:0]   col_idx;
    logic         last;
    logic         busy;
    logic         overflow;
    modport master (
        input  data_valid, h, y, col_ready,
        output col_valid, col, col_idx, last, busy, overflow
    );
    modport slave (
        output data_valid, h, y, col_ready,
        input  col_valid, col, col_idx, last, busy, overflow
    );
endinterface

// File: rtl/column_feeder.sv
// column_feeder: streams [H | Y] column by column with a one-frame shadow buffer (optional COLUMN_FEEDER_HEADROOM_EN halves outgoing components)
module column_feeder (
    input  logic              i_clk,
    input  logic              i_rst_n,
    column_feeder_if.master   bus
);
    typedef enum logic {IDLE, FEED} state_t;
    state_t       state, state_n;
    logic [2:0]   col, col_n;
    logic [959:0] act, act_n, shd, shd_n, frame;
    logic         shadow_full, shadow_full_n, overflow, overflow_n, hs;
    logic [47:0]  word;
    assign frame = {bus.y, bus.h};
    assign hs    = (state == FEED) && bus.col_ready;
    // state, buffers and flags; reset abandons any frame in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            col         <= '0;
            act         <= '0;
            shd         <= '0;
            shadow_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_n;
            col         <= col_n;
            act         <= act_n;
            shd         <= shd_n;
            shadow_full <= shadow_full_n;
            overflow    <= overflow_n;
        end
    end
    // next state: load, advance column, swap in shadow or new frame on the last beat, or park/drop arrivals
    always_comb begin
        state_n       = state;
        col_n         = col;
        act_n         = act;
        shd_n         = shd;
        shadow_full_n = shadow_full;
        overflow_n    = overflow;
        if (state == IDLE) begin
            if (bus.data_valid) begin
                act_n   = frame;
                col_n   = '0;
                state_n = FEED;
            end
        end else if (hs && col == 3'd4) begin
            col_n = '0;
            if (shadow_full) begin
                act_n         = shd;
                shadow_full_n = bus.data_valid;
                if (bus.data_valid) shd_n = frame;
            end else if (bus.data_valid) begin
                act_n = frame;
            end else begin
                state_n = IDLE;
            end
        end else begin
            if (hs) col_n = col + 3'd1;
            if (bus.data_valid) begin
                if (!shadow_full) begin
                    shd_n         = frame;
                    shadow_full_n = 1'b1;
                end else begin
                    overflow_n = 1'b1;
                end
            end
        end
    end
    // column mux: rows 1..4 of H column col+1, or Y when col is 4
    always_comb begin
        bus.col = '0;
        word    = '0;
        for (int r = 0; r < 4; r++) begin
            word = (col == 3'd4) ? act[768 + 48*r +: 48] : act[48*(4*r + int'(col[1:0])) +: 48];
`ifdef COLUMN_FEEDER_HEADROOM_EN
            bus.col[48*r +: 48] = {word[47], word[47:25], word[23], word[23:1]};
`else
            bus.col[48*r +: 48] = word;
`endif
        end
    end
    assign bus.col_valid = (state == FEED);
    assign bus.col_idx   = col;
    assign bus.last      = (state == FEED) && (col == 3'd4);
    assign bus.busy      = (state == FEED) || shadow_full;
    assign bus.overflow  = overflow;
endmodule

// File: tb/tb_column_feeder.sv
// tb_column_feeder: directed and random frames checked against a queue-of-frames model
module tb_column_feeder;
    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    column_feeder_if ifc();
    column_feeder dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(ifc.master));
    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad = 0;
    logic [959:0] fq[$];
    int pos = 0;
    logic ovf_exp = 1'b0;

    function automatic logic [47:0] hrc(logic [959:0] f, int r, int c);
        return f[48*(4*(r-1)+(c-1)) +: 48];
    endfunction

    function automatic logic [47:0] yr(logic [959:0] f, int r);
        return f[768 + 48*(r-1) +: 48];
    endfunction

    function automatic logic [47:0] scale(logic [47:0] w);
`ifdef COLUMN_FEEDER_HEADROOM_EN
        logic signed [23:0] im, re;
        im = w[47:24];
        re = w[23:0];
        return {im >>> 1, re >>> 1};
`else
        return w;
`endif
    endfunction

    function automatic logic [191:0] exp_col(logic [959:0] f, int k);
        logic [191:0] v;
        for (int r = 1; r <= 4; r++)
            v[48*(r-1) +: 48] = scale(k < 4 ? hrc(f, r, k+1) : yr(f, r));
        return v;
    endfunction

    function automatic logic [959:0] pat(int b);
        logic [959:0] f;
        for (int r = 1; r <= 4; r++) begin
            for (int c = 1; c <= 4; c++) f[48*(4*(r-1)+(c-1)) +: 48] = 48'(b*256 + r*16 + c);
            f[768 + 48*(r-1) +: 48] = {24'h00000F, 24'(b*256 + r)};
        end
        return f;
    endfunction

    function automatic logic [959:0] rnd_frame();
        logic [959:0] f;
        for (int i = 0; i < 30; i++) f[32*i +: 32] = $urandom;
        return f;
    endfunction

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic check_outputs();
        chk("valid", 192'(ifc.col_valid), 192'(fq.size() > 0));
        chk("busy", 192'(ifc.busy), 192'(fq.size() > 0));
        chk("overflow", 192'(ifc.overflow), 192'(ovf_exp));
        if (fq.size() > 0) begin
            chk("col", ifc.col, exp_col(fq[0], pos));
            chk("idx", 192'(ifc.col_idx), 192'(pos));
            chk("last", 192'(ifc.last), 192'(pos == 4));
        end
    endtask

    task automatic check_reset_zero();
        chk("rst_valid", 192'(ifc.col_valid), 192'(0));
        chk("rst_idx", 192'(ifc.col_idx), 192'(0));
        chk("rst_last", 192'(ifc.last), 192'(0));
        chk("rst_col", ifc.col, 192'(0));
        chk("rst_busy", 192'(ifc.busy), 192'(0));
        chk("rst_overflow", 192'(ifc.overflow), 192'(0));
    endtask

    task automatic step(input logic dv, input logic [959:0] f, input logic rdy);
        check_outputs();
        ifc.data_valid = dv;
        ifc.h = f[767:0];
        ifc.y = f[959:768];
        ifc.col_ready = rdy;
        if (fq.size() > 0 && rdy) begin
            if (pos == 4) begin
                void'(fq.pop_front());
                pos = 0;
            end else begin
                pos++;
            end
        end
        if (dv) begin
            if (fq.size() < 2) fq.push_back(f);
            else ovf_exp = 1'b1;
        end
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, rdy);
    endtask

    logic [959:0] f9;

    initial begin
        ifc.data_valid = 1'b0;
        ifc.h = '0;
        ifc.y = '0;
        ifc.col_ready = 1'b0;
        repeat (2) @(negedge i_clk);
        check_reset_zero();
        i_rst_n = 1'b1;
        @(negedge i_clk);
        // single frame, ready held high
        step(1'b1, pat(0), 1'b1);
        chk("idx0_cols", ifc.col, {scale(48'h41), scale(48'h31), scale(48'h21), scale(48'h11)});
        idle(7, 1'b1);
        // backpressure 1,0,0,1,...
        step(1'b1, pat(1), 1'b1);
        for (int i = 1; i < 20; i++) step(1'b0, '0, (i % 3) == 0);
        // second frame arrives while idx 2 is presented
        step(1'b1, pat(2), 1'b1);
        idle(2, 1'b1);
        step(1'b1, pat(3), 1'b1);
        idle(10, 1'b1);
        // three frames during a stalled stream
        step(1'b1, pat(4), 1'b0);
        step(1'b1, pat(5), 1'b0);
        step(1'b1, pat(6), 1'b0);
        idle(3, 1'b0);
        idle(12, 1'b1);
        chk("overflow_sticky", 192'(ifc.overflow), 192'(1));
        // asynchronous reset while idx 3 is presented
        step(1'b1, pat(7), 1'b1);
        idle(3, 1'b1);
        chk("pre_rst_idx", 192'(ifc.col_idx), 192'(3));
        #2 i_rst_n = 1'b0;
        #1 check_reset_zero();
        fq.delete();
        pos = 0;
        ovf_exp = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step(1'b1, pat(8), 1'b1);
        idle(7, 1'b1);
        // negative/odd h11 to exercise component scaling
        f9 = pat(9);
        f9[47:0] = {24'h800001, 24'h000003};
        step(1'b1, f9, 1'b1);
`ifdef COLUMN_FEEDER_HEADROOM_EN
        chk("h11_row1", 192'(ifc.col[47:0]), 192'(48'hC00000_000001));
`else
        chk("h11_row1", 192'(ifc.col[47:0]), 192'(48'h800001_000003));
`endif
        idle(6, 1'b1);
        // random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 5) == 0, rnd_frame(), $urandom_range(0, 2) != 0);
        idle(20, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
